// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and strobe sequencer for the shared 256x8 data RAM.
// Port 0 is the CPU core and port 1 is the loader/DMA. Each granted request runs the
// fixed sequence IDLE -> SETUP -> ACCESS -> RELEASE, so one access takes 4 cycles.
module ram_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_read,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic          last_gnt;   // 1 = port 1 was granted last
  logic          win;        // port currently being served
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          drive;      // data bus drive enable, only ever set for writes
  logic          pick1_c;

  // The data bus is driven only while a write owns the RAM.
  assign ram_data = drive ? wdata_q : {DW{1'bz}};

  // Choose the winning port from the current requests and the last-grant pointer.
  always_comb begin
    pick1_c = 1'b0;
    if (req0 && req1) begin
      pick1_c = (FIXED_PRIO != 32'd0) ? 1'b0 : ~last_gnt;
    end else begin
      pick1_c = req1;
    end
  end

  // Sequencer state plus every registered output, including the RAM strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      win       <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      drive     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win      <= pick1_c;
            we_q     <= pick1_c ? we1 : we0;
            wdata_q  <= pick1_c ? wdata1 : wdata0;
            ram_addr <= pick1_c ? addr1 : addr0;
            ram_en   <= 1'b1;
            ram_read <= pick1_c ? ~we1 : ~we0;
            drive    <= pick1_c ? we1 : we0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // The rising edge of ram_write commits the write inside the RAM.
          ram_write <= we_q;
          state     <= ACCESS;
        end
        ACCESS: begin
          ram_write <= 1'b0;
          ram_read  <= 1'b0;
          if (!we_q) begin
            rdata  <= ram_data;
            ram_en <= 1'b0;
          end
          ack0     <= ~win;
          ack1     <= win;
          last_gnt <= win;
          state    <= RELEASE;
        end
        RELEASE: begin
          // Write address, enable and data were held through this cycle for hold margin.
          ram_en <= 1'b0;
          drive  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 256x8 RAM.
// A round-robin instance (rr) is fully checked; a fixed-priority instance (fp) shares
// the same inputs and is checked only for tie ordering.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;

  logic       a0, a1, busy, en, rd, wr;
  logic [7:0] rdata, raddr;
  wire  [7:0] rdat;

  logic       f_a0, f_a1, f_busy, f_en, f_rd, f_wr;
  logic [7:0] f_rdata, f_raddr;
  wire  [7:0] f_rdat;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic mon_on = 1'b0;

  logic [7:0] mem [256] = '{default: 8'h00};

  ram_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(a0), .ack1(a1), .rdata(rdata), .busy(busy),
    .ram_en(en), .ram_read(rd), .ram_write(wr), .ram_addr(raddr),
    .ram_data(rdat)
  );

  ram_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(f_a0), .ack1(f_a1), .rdata(f_rdata), .busy(f_busy),
    .ram_en(f_en), .ram_read(f_rd), .ram_write(f_wr), .ram_addr(f_raddr),
    .ram_data(f_rdat)
  );

  // RAM model: combinational read data, commit on the ram_write rising edge.
  assign rdat = (en && rd) ? mem[raddr] : 8'hzz;
  always @(posedge wr) begin
    mem[raddr] = rdat;
    wr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus safety and idle strobe checks every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_wr_overlap", {31'b0, rd && wr}, 32'd0);
      if (!busy) chk("idle_strobes", {29'b0, en, rd, wr}, 32'd0);
    end
  end

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    bit         chg;
  } vec_t;

  vec_t tv [12];

  // One request on one port, with latency, strobe, bus and result checks.
  task automatic txn(input bit port, input bit we, input logic [7:0] addr,
                     input logic [7:0] wd, input logic [7:0] exp, input bit chg);
    int n;
    int w0;
    bit got;
    @(posedge clk); #1;
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    w0  = wr_cnt;
    n   = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 1) begin
        if (!port) addr0 = addr + 8'd1;
        else       addr1 = addr + 8'd1;
      end
      if (n <= 2) begin
        chk("ram_addr", raddr, addr);
        chk("ram_en", en, 1);
        chk("ram_read", rd, !we);
      end
      if (we && n <= 3) chk("wr_bus_data", rdat, wd);
      if (a0 || a1) begin
        got = 1'b1;
        chk("ack_port", a1, port);
        chk("ack_both", a0 && a1, 0);
      end
    end
    chk("ack_latency", n, 3);
    chk("wr_edges", wr_cnt - w0, we);
    if (!we) chk("rdata", rdata, exp);
    @(posedge clk); #1;
    if (!port) req0 = 1'b0;
    else       req1 = 1'b0;
    chk("ack_pulse", {a0, a1}, 0);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int ack_cyc[$];
    int ack_prt[$];
    int f0, f1, n, w0;
    bit got;

    tv[0]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 8'h7F, 8'h5A, 8'h00, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 8'h00, 8'h99, 8'h00, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h99, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 8'h20, 8'h77, 8'h00, 1'b1};
    tv[10] = '{1'b1, 1'b0, 8'h21, 8'h00, 8'h00, 1'b0};
    tv[11] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {26'b0, a0, a1, busy, en, rd, wr}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", raddr, 0);
    chk("rst_fp_outs", {26'b0, f_a0, f_a1, f_busy, f_en, f_rd, f_wr}, 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(tv[i].port, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].exp, tv[i].chg);
    end

    // Both ports request writes continuously from reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 8'h01; wdata0 = 8'h11; addr1 = 8'h02; wdata1 = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = 0;
    f1 = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (a0) begin ack_cyc.push_back(i); ack_prt.push_back(0); end
      if (a1) begin ack_cyc.push_back(i); ack_prt.push_back(1); end
      f0 += int'(f_a0);
      f1 += int'(f_a1);
    end
    chk("rr_ack_count", ack_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_cyc.size()) begin
        chk("rr_ack_order", ack_prt[k], k % 2);
        chk("rr_ack_cycle", ack_cyc[k], 3 + 4 * k);
      end
    end
    chk("fp_ack0_count", f0, 4);
    chk("fp_no_ack1_held", f1, 0);

    req0 = 1'b0;
    n    = 0;
    got  = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (f_a1) got = 1'b1;
    end
    chk("fp_ack1_after_drop", n, 3);
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    txn(1'b0, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
    txn(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 1'b0);

    // Reset lands on the SETUP cycle of a write to 0x10.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hFF;
    w0 = wr_cnt;
    @(posedge clk); #1;
    chk("mid_setup_busy", busy, 1);
    chk("mid_setup_wr", wr, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_outs", {26'b0, a0, a1, busy, en, rd, wr}, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_addr", raddr, 0);
    chk("mid_rst_no_write", wr_cnt - w0, 0);
    req0  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ack", {a0, a1}, 0);
    end
    txn(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
